// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - register-mapped sample/coefficient sequencer for the FIR datapath
module fir_seq_ctrl #(
    parameter int DATA_W      = 16,
    parameter int COEFF_W     = 16,
    parameter int ACC_W       = 32,
    parameter int NUM_TAPS    = 16,
    parameter int SFIFO_DEPTH = 4,
    parameter int RFIFO_DEPTH = 4,
    parameter int TAP_W       = $clog2(NUM_TAPS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               reg_valid_i,
    input  logic               reg_write_i,
    input  logic [4:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               reg_ready_o,
    output logic               reg_error_o,
    output logic               clr_c_o,
    output logic               accel_en_o,
    output logic               coeff_we_o,
    output logic [TAP_W-1:0]   coeff_addr_o,
    output logic [COEFF_W-1:0] coeff_o,
    output logic [DATA_W-1:0]  sample_o,
    input  logic [ACC_W-1:0]   mac_result_i,
    input  logic               result_valid_i,
    input  logic               busy_i
);
    localparam int SPW = $clog2(SFIFO_DEPTH);
    localparam int RPW = $clog2(RFIFO_DEPTH);

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_IDX    = 5'h08;
    localparam logic [4:0] A_COEFF  = 5'h0C;
    localparam logic [4:0] A_SAMPLE = 5'h10;
    localparam logic [4:0] A_RESULT = 5'h14;
    localparam logic [4:0] A_COUNT  = 5'h18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic en_q, en_d;
    logic [TAP_W-1:0] idx_q, idx_d;
    logic [15:0] count_q, count_d;
    logic sovf_q, sovf_d, rudf_q, rudf_d, cerr_q, cerr_d;
    logic accel_en_q, accel_en_d, clr_c_q, clr_c_d, coeff_we_q, coeff_we_d;
    logic [TAP_W-1:0] coeff_addr_q, coeff_addr_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;
    logic [DATA_W-1:0] sample_q, sample_d;

    logic [DATA_W-1:0] s_mem_q [SFIFO_DEPTH];
    logic [DATA_W-1:0] s_mem_d [SFIFO_DEPTH];
    logic [SPW-1:0] s_wr_q, s_wr_d, s_rd_q, s_rd_d;
    logic [SPW:0] s_cnt_q, s_cnt_d;
    logic [ACC_W-1:0] r_mem_q [RFIFO_DEPTH];
    logic [ACC_W-1:0] r_mem_d [RFIFO_DEPTH];
    logic [RPW-1:0] r_wr_q, r_wr_d, r_rd_q, r_rd_d;
    logic [RPW:0] r_cnt_q, r_cnt_d;

    logic wr, rd, addr_ok, s_empty, s_full, r_empty, r_full;
    logic clear_req, issue_go, s_full_eff, s_push, r_push, r_pop, coeff_ok;
    logic wr_coeff, wr_sample, rd_result;
    logic unused_wdata;

    assign unused_wdata = ^reg_wdata_i;

    assign wr = reg_valid_i & reg_write_i;
    assign rd = reg_valid_i & ~reg_write_i;
    assign addr_ok = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i <= A_COUNT);

    assign s_empty = (s_cnt_q == '0);
    assign s_full  = (s_cnt_q == (SPW+1)'(SFIFO_DEPTH));
    assign r_empty = (r_cnt_q == '0);
    assign r_full  = (r_cnt_q == (RPW+1)'(RFIFO_DEPTH));

    assign wr_coeff  = wr && (reg_addr_i == A_COEFF);
    assign wr_sample = wr && (reg_addr_i == A_SAMPLE);
    assign rd_result = rd && (reg_addr_i == A_RESULT);
    assign clear_req = wr && (reg_addr_i == A_CTRL) && reg_wdata_i[1];

    assign issue_go = (state_q == ST_IDLE) && en_q && !s_empty && !r_full && !busy_i && !clear_req;
    // Fullness seen by the bus accounts for the FSM pop in the same cycle.
    assign s_full_eff = s_full && !issue_go;
    assign s_push   = wr_sample && !s_full_eff;
    assign r_push   = (state_q == ST_WAIT) && result_valid_i && !clear_req;
    assign r_pop    = rd_result && !r_empty;
    assign coeff_ok = (state_q == ST_IDLE) && s_empty;

    assign reg_ready_o = 1'b1;
    assign reg_error_o = reg_valid_i && (!addr_ok || (wr_coeff && !coeff_ok) ||
                         (wr_sample && s_full_eff) || (rd_result && r_empty));

    always_comb begin
        reg_rdata_o = '0;
        if (rd) begin
            case (reg_addr_i)
                A_CTRL:   reg_rdata_o = {31'b0, en_q};
                A_STATUS: reg_rdata_o = {22'b0, cerr_q, rudf_q, sovf_q, r_full, r_empty,
                                         s_empty, s_full, 1'b0, state_q};
                A_IDX:    reg_rdata_o = 32'(idx_q);
                A_RESULT: reg_rdata_o = r_empty ? 32'b0 : 32'(r_mem_q[r_rd_q]);
                A_COUNT:  reg_rdata_o = {16'b0, count_q};
                default:  reg_rdata_o = '0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        idx_d        = idx_q;
        count_d      = count_q;
        sovf_d       = sovf_q;
        rudf_d       = rudf_q;
        cerr_d       = cerr_q;
        coeff_we_d   = 1'b0;
        coeff_addr_d = coeff_addr_q;
        coeff_d      = coeff_q;
        sample_d     = sample_q;
        s_mem_d      = s_mem_q;
        s_wr_d       = s_wr_q;
        s_rd_d       = s_rd_q;
        s_cnt_d      = s_cnt_q;
        r_mem_d      = r_mem_q;
        r_wr_d       = r_wr_q;
        r_rd_d       = r_rd_q;
        r_cnt_d      = r_cnt_q;

        case (state_q)
            ST_IDLE:  if (issue_go) begin
                          state_d  = ST_ISSUE;
                          sample_d = s_mem_q[s_rd_q];
                      end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (result_valid_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (s_push) begin
            s_mem_d[s_wr_q] = reg_wdata_i[DATA_W-1:0];
            s_wr_d = s_wr_q + SPW'(1);
        end
        if (issue_go) s_rd_d = s_rd_q + SPW'(1);
        if (s_push && !issue_go) s_cnt_d = s_cnt_q + (SPW+1)'(1);
        else if (!s_push && issue_go) s_cnt_d = s_cnt_q - (SPW+1)'(1);
        if (wr_sample && s_full_eff) sovf_d = 1'b1;

        if (r_push) begin
            r_mem_d[r_wr_q] = mac_result_i;
            r_wr_d  = r_wr_q + RPW'(1);
            count_d = count_q + 16'd1;
        end
        if (r_pop) r_rd_d = r_rd_q + RPW'(1);
        if (r_push && !r_pop) r_cnt_d = r_cnt_q + (RPW+1)'(1);
        else if (!r_push && r_pop) r_cnt_d = r_cnt_q - (RPW+1)'(1);
        if (rd_result && r_empty) rudf_d = 1'b1;

        if (wr && reg_addr_i == A_CTRL) en_d = reg_wdata_i[0];
        if (wr && reg_addr_i == A_IDX) idx_d = reg_wdata_i[TAP_W-1:0];
        if (wr_coeff) begin
            if (coeff_ok) begin
                coeff_we_d   = 1'b1;
                coeff_addr_d = idx_q;
                coeff_d      = reg_wdata_i[COEFF_W-1:0];
                idx_d = (idx_q == TAP_W'(NUM_TAPS-1)) ? '0 : idx_q + TAP_W'(1);
            end else begin
                cerr_d = 1'b1;
            end
        end

        // Clear wins over everything else; EN and IDX survive it.
        if (clear_req) begin
            state_d = ST_CLEAR;
            s_wr_d  = '0;
            s_rd_d  = '0;
            s_cnt_d = '0;
            r_wr_d  = '0;
            r_rd_d  = '0;
            r_cnt_d = '0;
            count_d = '0;
            sovf_d  = 1'b0;
            rudf_d  = 1'b0;
            cerr_d  = 1'b0;
        end

        accel_en_d = (state_d == ST_ISSUE);
        clr_c_d    = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            en_q         <= 1'b0;
            idx_q        <= '0;
            count_q      <= '0;
            sovf_q       <= 1'b0;
            rudf_q       <= 1'b0;
            cerr_q       <= 1'b0;
            accel_en_q   <= 1'b0;
            clr_c_q      <= 1'b0;
            coeff_we_q   <= 1'b0;
            coeff_addr_q <= '0;
            coeff_q      <= '0;
            sample_q     <= '0;
            s_mem_q      <= '{default: '0};
            s_wr_q       <= '0;
            s_rd_q       <= '0;
            s_cnt_q      <= '0;
            r_mem_q      <= '{default: '0};
            r_wr_q       <= '0;
            r_rd_q       <= '0;
            r_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            sovf_q       <= sovf_d;
            rudf_q       <= rudf_d;
            cerr_q       <= cerr_d;
            accel_en_q   <= accel_en_d;
            clr_c_q      <= clr_c_d;
            coeff_we_q   <= coeff_we_d;
            coeff_addr_q <= coeff_addr_d;
            coeff_q      <= coeff_d;
            sample_q     <= sample_d;
            s_mem_q      <= s_mem_d;
            s_wr_q       <= s_wr_d;
            s_rd_q       <= s_rd_d;
            s_cnt_q      <= s_cnt_d;
            r_mem_q      <= r_mem_d;
            r_wr_q       <= r_wr_d;
            r_rd_q       <= r_rd_d;
            r_cnt_q      <= r_cnt_d;
        end
    end

    assign accel_en_o   = accel_en_q;
    assign clr_c_o      = clr_c_q;
    assign coeff_we_o   = coeff_we_q;
    assign coeff_addr_o = coeff_addr_q;
    assign coeff_o      = coeff_q;
    assign sample_o     = sample_q;
endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Register-mapped sequencer for the FIR datapath (`top`), instantiated between the X-HEEP register bus and the accelerator core inside `fir_accelerator`. It decodes CPU register accesses and loads coefficients into the datapath. It buffers incoming samples in a small FIFO and issues each one to the datapath with a one-cycle `accelerateEn`-style pulse. It then captures each MAC result into a result FIFO for the CPU to read.

## Interface
- `DATA_W`, 16, sample width
- `COEFF_W`, 16, coefficient width
- `ACC_W`, 32, MAC result width (≤32)
- `NUM_TAPS`, 16, coefficient count; `TAP_W = $clog2(NUM_TAPS)`
- `SFIFO_DEPTH`, 4, sample FIFO depth (power of 2)
- `RFIFO_DEPTH`, 4, result FIFO depth (power of 2)

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `reg_valid_i`  in  1  bus request
- `reg_write_i`  in  1  1 = write, 0 = read
- `reg_addr_i`  in  5  byte address
- `reg_wdata_i`  in  32  write data
- `reg_rdata_o`  out  32  read data; combinational, same cycle
- `reg_ready_o`  out  1  tied to 1
- `reg_error_o`  out  1  combinational; high for a rejected access
- `clr_c_o`  out  1  datapath accumulator/delay-line clear pulse
- `accel_en_o`  out  1  datapath start pulse
- `coeff_we_o`  out  1  coefficient write strobe
- `coeff_addr_o`  out  TAP_W  coefficient index
- `coeff_o`  out  COEFF_W  coefficient value
- `sample_o`  out  DATA_W  sample presented to the datapath
- `mac_result_i`  in  ACC_W  datapath result
- `result_valid_i`  in  1  result strobe
- `busy_i`  in  1  datapath busy

## Operation
Register map (other addresses → `reg_error_o`=1, no side effect, rdata 0):
- 0x00 CTRL (RW):
  - bit0 EN: enables sample issue.
  - bit1 CLEAR: write-1 self-clearing; reads 0.
- 0x04 STATUS (RO):
  - bits 2:0: state.
  - bit3: sample FIFO full. bit4: sample FIFO empty.
  - bit5: result FIFO empty. bit6: result FIFO full.
  - bit7: sticky SOVF. bit8: sticky RUDF. bit9: sticky CERR.
- 0x08 COEFF_IDX (RW, TAP_W bits).
- 0x0C COEFF_DATA (WO). A write pulses `coeff_we_o` for 1 cycle with `coeff_addr_o`=IDX and `coeff_o`=wdata[COEFF_W-1:0].
  - IDX then post-increments, wrapping NUM_TAPS-1 → 0.
  - Accepted only when the state is IDLE and the sample FIFO is empty. Otherwise: error, CERR set, no strobe, IDX unchanged.
- 0x10 SAMPLE (WO). Pushes wdata[DATA_W-1:0].
  - If the FIFO is full: error, SOVF set, sample dropped.
- 0x14 RESULT (RO). Returns the head, zero-extended, and pops it.
  - If the FIFO is empty: rdata 0, error, RUDF set.
- 0x18 COUNT (RO). 16-bit count of results captured; wraps at 0xFFFF → 0.

FSM states (STATUS encoding):
- IDLE (0): go to ISSUE when EN && sample FIFO non-empty && result FIFO not full && !busy_i.
- ISSUE (1): pop the sample into the `sample_o` register and assert `accel_en_o` for this single cycle; then WAIT.
- WAIT (2): hold `sample_o`. On `result_valid_i`: push `mac_result_i`, increment COUNT, go to IDLE.
- CLEAR (3): assert `clr_c_o` for this single cycle; then IDLE.

Rules:
- A CLEAR write takes effect from any state, including mid-WAIT (the in-flight result is discarded). Its effects:
  - next state CLEAR;
  - both FIFOs flushed;
  - sticky bits and COUNT zeroed;
  - IDX and EN preserved.
- CLEAR has priority over `result_valid_i` in the same cycle.
- `result_valid_i` outside WAIT is ignored.
- A simultaneous SAMPLE push and FSM pop on a full FIFO: the push is accepted, because fullness is evaluated after the pop.
- A simultaneous RESULT pop and FSM push on a full result FIFO cannot occur, because the FSM never issues while the result FIFO is full.
- Clearing EN while in WAIT completes the current sample; no new issue follows.

## Timing
- Reset values:
  - all outputs 0 (except `reg_ready_o`=1);
  - state IDLE; FIFOs empty; EN=0; IDX=0; COUNT=0; sticky bits 0.
- All datapath outputs are registered.
- Register write at edge t: side effects are visible at t+1.
- Coefficient write at t: `coeff_we_o` high during cycle t+1.
- Sample issue: SAMPLE write at t → IDLE evaluates at t+1 → ISSUE (`accel_en_o`=1) at t+2 → WAIT from t+3.
- Result push on the `result_valid_i` edge; readable the next cycle.
- Per-sample throughput: 2 cycles plus datapath latency.
- CLEAR write at t → `clr_c_o` high during t+1.

## Test plan
- Reset checks:
  - Assert `rst_ni`=0 mid-WAIT → all outputs 0 immediately.
  - After release, STATUS reads 0x030 (both FIFOs empty, IDLE).
- Coefficient load: IDX=14, then write COEFF_DATA 0x1111, 0x2222, 0x3333 → three strobes at addresses 14, 15, 0 with matching data; IDX then reads 1.
- Sample flow, EN=1, datapath model returning sample×2 after 5 cycles:
  - Write samples 3, 7.
  - Each `accel_en_o` pulse lasts exactly 1 cycle, with `sample_o` held until the result.
  - RESULT reads give 6, then 14; COUNT reads 2.
- Sample overflow: EN=0, write 5 samples → 5th returns error, SOVF=1, FIFO full. Set EN=1 → exactly 4 issues.
- Backpressure and underflow:
  - Fill the result FIFO with 4 results and queue a 5th sample → no issue until one RESULT read.
  - Read an empty RESULT → rdata 0, error, RUDF=1.
- CLEAR and coefficient lock:
  - CLEAR during WAIT → `clr_c_o` pulse; a later `result_valid_i` is ignored; FIFOs and COUNT are zeroed; EN and IDX are retained.
  - A COEFF_DATA write during WAIT returns error and sets CERR with no strobe.
